// File: rtl/siso_frame_ctrl.sv
// Framed serial transmit sequencer: start bit, DATA_W data bits, optional even parity, stop bit.
// Optional parity bit between data and stop is enabled by defining SISO_FRAME_PARITY_EN.
module siso_frame_ctrl #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int MSB_FIRST    = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_serial_out,
  output logic              o_bit_strobe,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

`ifdef SISO_FRAME_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_clk_cnt, w_clk_nxt;
  logic [BW-1:0]     r_bit_cnt, w_bit_nxt;
  logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
  logic              w_last;
  logic              w_done_nxt;
  logic              w_serial_nxt;
  logic              w_strobe_nxt;
  logic              w_edge_nxt;
  logic              r_ready, r_serial, r_strobe, r_busy, r_done;
`ifdef SISO_FRAME_PARITY_EN
  logic              r_parity, w_parity_nxt;
`endif

  assign w_last = (r_clk_cnt == CLK_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_shreg_nxt = r_shreg;
    w_done_nxt  = 1'b0;
    w_clk_nxt   = (r_state == S_IDLE || w_last) ? '0 : r_clk_cnt + CW'(1);
`ifdef SISO_FRAME_PARITY_EN
    w_parity_nxt = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_state_nxt = S_START;
          w_bit_nxt   = '0;
          w_shreg_nxt = i_data;
`ifdef SISO_FRAME_PARITY_EN
          w_parity_nxt = ^i_data;
`endif
        end
      end
      S_START: if (w_last) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_last) begin
          w_shreg_nxt = (MSB_FIRST != 0) ? {r_shreg[DATA_W-2:0], 1'b0}
                                         : {1'b0, r_shreg[DATA_W-1:1]};
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_nxt = '0;
`ifdef SISO_FRAME_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit_cnt + BW'(1);
          end
        end
      end
`ifdef SISO_FRAME_PARITY_EN
      S_PARITY: if (w_last) w_state_nxt = S_STOP;
`endif
      S_STOP: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so every port comes straight from a flop.
  always_comb begin
    w_edge_nxt   = (MSB_FIRST != 0) ? w_shreg_nxt[DATA_W-1] : w_shreg_nxt[0];
    w_strobe_nxt = (w_state_nxt != S_IDLE) && (w_clk_nxt == '0);
    case (w_state_nxt)
      S_START:  w_serial_nxt = 1'b0;
      S_DATA:   w_serial_nxt = w_edge_nxt;
`ifdef SISO_FRAME_PARITY_EN
      S_PARITY: w_serial_nxt = w_parity_nxt;
`endif
      default:  w_serial_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_ready   <= 1'b1;
      r_serial  <= 1'b1;
      r_strobe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef SISO_FRAME_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shreg   <= w_shreg_nxt;
      r_ready   <= (w_state_nxt == S_IDLE);
      r_serial  <= w_serial_nxt;
      r_strobe  <= w_strobe_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= w_done_nxt;
`ifdef SISO_FRAME_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end

  assign o_ready      = r_ready;
  assign o_serial_out = r_serial;
  assign o_bit_strobe = r_strobe;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// Directed bench for siso_frame_ctrl: LSB-first/4-clock instance and MSB-first/1-clock instance.
// Parity expectations follow SISO_FRAME_PARITY_EN when it is defined for the build.
module tb_siso_frame_ctrl;

`ifdef SISO_FRAME_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 10 + PAR;

  logic       clk = 1'b0;
  logic       rst, valid0, valid1, sel;
  logic [7:0] data;
  logic       rdy0, ser0, stb0, busy0, done0;
  logic       rdy1, ser1, stb1, busy1, done1;
  logic       rdy, ser, stb, busy, done;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  siso_frame_ctrl #(.DATA_W(8), .CLKS_PER_BIT(4), .MSB_FIRST(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid0),
    .o_ready(rdy0), .o_serial_out(ser0), .o_bit_strobe(stb0),
    .o_busy(busy0), .o_done(done0)
  );

  siso_frame_ctrl #(.DATA_W(8), .CLKS_PER_BIT(1), .MSB_FIRST(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid1),
    .o_ready(rdy1), .o_serial_out(ser1), .o_bit_strobe(stb1),
    .o_busy(busy1), .o_done(done1)
  );

  assign rdy  = sel ? rdy1  : rdy0;
  assign ser  = sel ? ser1  : ser0;
  assign stb  = sel ? stb1  : stb0;
  assign busy = sel ? busy1 : busy0;
  assign done = sel ? done1 : done0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_line(input int idx, input logic [7:0] d, input bit msb);
    logic [7:0] dv;
    dv = d;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return msb ? dv[8-idx] : dv[idx-1];
    if (PAR == 1 && idx == 9) return ^dv;
    return 1'b1;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ser"},  ser,  1);
    check({tag, "_rdy"},  rdy,  1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_stb"},  stb,  0);
  endtask

  // Called at a negedge with the word already offered; returns at the negedge of the done cycle.
  task automatic run(input logic [7:0] d, input bit hold, input logic [7:0] nd);
    int cpb, n, strobes, lowready;
    cpb = sel ? 1 : 4;
    n = NBITS * cpb;
    strobes = 0;
    lowready = 0;
    @(negedge clk);
    data = hold ? nd : 8'($urandom);
    if (sel) valid1 = hold; else valid0 = hold;
    for (int c = 0; c < n; c++) begin
      check("line",   ser,  exp_line(c / cpb, d, sel));
      check("strobe", stb,  (c % cpb) == 0);
      check("busy",   busy, 1);
      check("done",   done, 0);
      if (!rdy) lowready++;
      if (stb) strobes++;
      @(negedge clk);
    end
    check("ready_low_len", lowready, n);
    check("strobe_cnt",    strobes,  NBITS);
    check("done_pulse",    done, 1);
    check("ready_back",    rdy,  1);
    check("idle_line",     ser,  1);
    check("busy_clr",      busy, 0);
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; valid0 = 1'b1; valid1 = 1'b0; data = 8'h3C;
    repeat (3) begin
      @(negedge clk);
      check_idle("rst");
    end
    rst = 1'b0;
    run(8'h3C, 1'b0, 8'h00);

    @(negedge clk);
    check("done_one_cycle", done, 0);
    valid0 = 1'b1; data = 8'hA5;
    run(8'hA5, 1'b0, 8'h00);

    @(negedge clk);
    valid0 = 1'b1; data = 8'h00;
    run(8'h00, 1'b1, 8'hFF);
    run(8'hFF, 1'b0, 8'h00);

    @(negedge clk);
    valid0 = 1'b1; data = 8'h55;
    @(negedge clk);
    valid0 = 1'b0; data = 8'hAA;
    repeat (17) @(negedge clk);
    check("mid_data_bit3", ser, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("midrst");
    @(negedge clk);
    check_idle("midrst_after");
    valid0 = 1'b1; data = 8'h0F;
    run(8'h0F, 1'b0, 8'h00);

    @(negedge clk);
    valid0 = 1'b1; data = 8'h07;
    run(8'h07, 1'b0, 8'h00);
    @(negedge clk);
    valid0 = 1'b1; data = 8'h03;
    run(8'h03, 1'b0, 8'h00);

    @(negedge clk);
    sel = 1'b1;
    check_idle("dut1_idle");
    valid1 = 1'b1; data = 8'h80;
    run(8'h80, 1'b0, 8'h00);
    @(negedge clk);
    valid1 = 1'b1; data = 8'h3C;
    run(8'h3C, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/siso_frame_ctrl.md
Name: siso_frame_ctrl

Overview:
- Transmit sequencer for the serial-in/serial-out shift datapath.
- Accepts a parallel word over a valid/ready handshake, latches it, then drives a framed bit stream onto one serial line: start bit, DATA_W data bits, stop bit.
- Each bit is held for CLKS_PER_BIT clocks.
- A per-bit strobe is exported so a downstream shift chain can advance in lock-step with the line.

Parameters:
DATA_W, 8, data bits per frame (>=2)
CLKS_PER_BIT, 4, clocks per line bit (>=1)
MSB_FIRST, 0, 1 = data[DATA_W-1] sent first; 0 = data[0] sent first

Ports:
i_clk  input  1  clock; all logic rising-edge
i_rst  input  1  synchronous reset, active-high
i_data  input  DATA_W  word to send; sampled only on the accepting edge
i_valid  input  1  producer has a word
o_ready  output  1  controller can accept a word (IDLE only)
o_serial_out  output  1  framed serial line; idle level 1
o_bit_strobe  output  1  1-cycle pulse in the first cycle of every line bit (start, data, parity, stop)
o_busy  output  1  frame in progress (state != IDLE)
o_done  output  1  1-cycle pulse when a frame completes

Behaviour:
- Interface: single clock i_clk; reset i_rst is synchronous and active-high. All outputs are registered.
- Reset values: o_serial_out=1, o_ready=1, o_busy=0, o_done=0, o_bit_strobe=0. State is IDLE, counters are 0, the shift register is cleared.
- i_rst dominates: no transfer is accepted on an edge where i_rst=1.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Transfer: occurs on an edge with i_valid=1, o_ready=1 and i_rst=0.
  - The word is latched into an internal shift register.
  - State goes to START; o_ready drops and o_busy rises on that same edge.
- Bit timing:
  - clk_cnt counts 0..CLKS_PER_BIT-1 within each bit.
  - o_bit_strobe=1 when clk_cnt==0 for a bit.
  - The state advances when clk_cnt==CLKS_PER_BIT-1.
- START: o_serial_out=0.
- DATA: o_serial_out = current edge bit of the shift register. The register shifts by 1 at the end of each bit period. bit_cnt counts 0..DATA_W-1; leave DATA after bit DATA_W-1.
- STOP: o_serial_out=1.
  - On its final cycle, the next edge enters IDLE with o_ready=1, o_busy=0 and o_done=1 for exactly one cycle.
- Frame length:
  - o_ready is low for exactly (DATA_W+2)*CLKS_PER_BIT cycles after the accepting edge.
  - With parity enabled, it is low for (DATA_W+3)*CLKS_PER_BIT cycles.
- Back-to-back:
  - If i_valid is held, the next word is accepted on the first IDLE cycle, the same cycle o_done is high.
  - This leaves exactly one idle-level cycle between frames.
- Data stability: i_data and i_valid changes during a frame are ignored.
- Reset mid-frame: the next edge forces IDLE and o_serial_out=1. The latched word is discarded and no o_done is issued.
- CLKS_PER_BIT=1: every cycle is strobed and the controller is still correct. The clk_cnt width is max(1, clog2(CLKS_PER_BIT)).

Optional Feature:
- Macro: SISO_FRAME_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of all latched data bits) for CLKS_PER_BIT cycles and is strobed like the other bits.
- Undefined:
  - No PARITY state or logic exists; DATA goes directly to STOP.

Test Plan:
- Reset check: hold i_rst=1 for 3 cycles with i_valid=1 and i_data=0x3C.
  - Required: o_serial_out=1, o_ready=1, o_busy=0, o_done=0, no strobes, no frame started.
  - Release reset: the frame starts 1 cycle later.
- DATA_W=8, CLKS_PER_BIT=4, MSB_FIRST=0, send 0xA5.
  - Line sequence, each bit held 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - o_ready is low for 40 cycles; o_done pulses once on cycle 41; there are 10 o_bit_strobe pulses spaced 4 apart.
- MSB_FIRST=1, send 0x80.
  - Data bits on the line: 1,0,0,0,0,0,0,0, between start 0 and stop 1.
- Back-to-back: hold i_valid with 0x00 then 0xFF.
  - Second start bit falls exactly 1 idle cycle after the first frame's stop bit.
  - o_done and the second accept occur in the same cycle.
- Reset mid-frame: assert i_rst for 1 cycle during data bit 3 of 0x55.
  - Next cycle: o_serial_out=1, o_busy=0, o_ready=1, no o_done.
  - A following send of 0x0F is framed correctly.
- With SISO_FRAME_PARITY_EN defined, send 0x07.
  - Parity bit = 1 between data and stop.
  - o_ready is low for 44 cycles; 11 strobes.
  - Send 0x03: parity bit = 0.
